// File: rtl/instr_queue_if.sv
// Fetch/decode handshake bundle for instr_queue.
//   master : drives in_valid/in_pc/in_instr and out_ready (fetch + decode side)
//   slave  : the queue; drives in_ready, out_valid/out_pc/out_instr, count,
//            halt_seen
interface instr_queue_if #(
  parameter int DEPTH = 2,
  parameter int DW    = 16
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          in_valid;
  logic [DW-1:0] in_pc;
  logic [DW-1:0] in_instr;
  logic          in_ready;
  logic          out_valid;
  logic [DW-1:0] out_pc;
  logic [DW-1:0] out_instr;
  logic          out_ready;
  logic [CW-1:0] count;
  logic          halt_seen;

  modport master (
    output in_valid, in_pc, in_instr, out_ready,
    input  in_ready, out_valid, out_pc, out_instr, count, halt_seen
  );

  modport slave (
    input  in_valid, in_pc, in_instr, out_ready,
    output in_ready, out_valid, out_pc, out_instr, count, halt_seen
  );
endinterface

// File: rtl/instr_queue.sv
// Decoupling instruction buffer between fetch and decode.
// Captures {nxt_pc, instr} pairs from fetch and hands them to decode in order
// over a valid/ready handshake. Enqueueing a HALT (top five opcode bits zero)
// sets a sticky halt_seen that blocks further enqueues until flush or rst.
// Ports:
//   clk   : clock, all state on posedge
//   rst   : asynchronous active-high reset
//   flush : synchronous discard of all entries and halt_seen
//   bus   : instr_queue_if slave modport (handshake, head data, count, halt)
module instr_queue #(
  parameter int DEPTH = 2,
  parameter int DW    = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  instr_queue_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DW-1:0] mem_pc    [DEPTH];
  logic [DW-1:0] mem_instr [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count_q;
  logic          halt_q;
  logic          enq;
  logic          deq;
  logic          is_halt;

  assign bus.in_ready  = (count_q != CW'(DEPTH)) & ~halt_q;
  assign bus.out_valid = (count_q != '0);
  // No empty bypass: head data is always the stored entry, stale when empty.
  assign bus.out_pc    = mem_pc[rd_ptr];
  assign bus.out_instr = mem_instr[rd_ptr];
  assign bus.count     = count_q;
  assign bus.halt_seen = halt_q;

  assign enq     = bus.in_valid & bus.in_ready;
  assign deq     = bus.out_valid & bus.out_ready;
  assign is_halt = (bus.in_instr[DW-1 -: 5] == 5'b00000);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      halt_q  <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_pc[i]    <= '0;
        mem_instr[i] <= '0;
      end
    end else if (flush) begin
      // Storage is left as-is; only bookkeeping is cleared. A same-cycle
      // enqueue is dropped by not writing it.
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      halt_q  <= 1'b0;
    end else begin
      if (enq) begin
        mem_pc[wr_ptr]    <= bus.in_pc;
        mem_instr[wr_ptr] <= bus.in_instr;
        wr_ptr            <= wr_ptr + AW'(1);
        if (is_halt) halt_q <= 1'b1;
      end
      if (deq) rd_ptr <= rd_ptr + AW'(1);
      if (enq && !deq)      count_q <= count_q + CW'(1);
      else if (deq && !enq) count_q <= count_q - CW'(1);
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(enq && !deq && count_q == CW'(DEPTH)));
  a_no_underflow: assert property (@(posedge clk) disable iff (rst)
    !(deq && count_q == '0));
  a_count_range: assert property (@(posedge clk) disable iff (rst)
    count_q <= CW'(DEPTH));
endmodule

// File: tb/tb_instr_queue.sv
module tb_instr_queue;
  localparam int DEPTH = 2;
  localparam int DW    = 16;

  logic clk;
  logic rst;
  logic flush;
  bit   chk_en;

  instr_queue_if #(.DEPTH(DEPTH), .DW(DW)) bus ();

  instr_queue #(.DEPTH(DEPTH), .DW(DW)) dut (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: a plain FIFO of {pc, instr} plus a sticky halt bit.
  logic [31:0] mq[$];
  logic [31:0] delivered[$];
  bit          m_halt;
  bit          m_enq;
  bit          m_deq;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle compare of DUT against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("in_ready",  32'(bus.in_ready),  32'((mq.size() < DEPTH) && !m_halt));
      chk("out_valid", 32'(bus.out_valid), 32'(mq.size() > 0));
      chk("count",     32'(bus.count),     32'(mq.size()));
      chk("halt_seen", 32'(bus.halt_seen), 32'(m_halt));
      if (mq.size() > 0) begin
        chk("out_pc",    32'(bus.out_pc),    32'(mq[0][31:16]));
        chk("out_instr", 32'(bus.out_instr), 32'(mq[0][15:0]));
      end
    end
  end

  task automatic cyc(input bit fl, input bit iv, input logic [15:0] pc,
                     input logic [15:0] ins, input bit ordy);
    flush         = fl;
    bus.in_valid  = iv;
    bus.in_pc     = pc;
    bus.in_instr  = ins;
    bus.out_ready = ordy;
    @(posedge clk);
    m_enq = iv && !m_halt && (mq.size() < DEPTH);
    m_deq = ordy && (mq.size() > 0);
    if (m_deq) delivered.push_back(mq[0]);
    if (fl) begin
      mq.delete();
      m_halt = 1'b0;
    end else begin
      if (m_deq) void'(mq.pop_front());
      if (m_enq) begin
        mq.push_back({pc, ins});
        if (ins[15:11] == 5'b00000) m_halt = 1'b1;
      end
    end
    #1;
  endtask

  initial begin
    int sent;
    int budget;
    int base;
    logic [15:0] r_ins;

    rst = 1'b1;
    flush = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_pc = '0;
    bus.in_instr = '0;
    bus.out_ready = 1'b0;
    m_halt = 1'b0;
    #12;
    chk("rst_out_valid", 32'(bus.out_valid), 0);
    chk("rst_count",     32'(bus.count), 0);
    chk("rst_halt",      32'(bus.halt_seen), 0);
    chk("rst_in_ready",  32'(bus.in_ready), 1);
    chk("rst_out_pc",    32'(bus.out_pc), 0);
    chk("rst_out_instr", 32'(bus.out_instr), 0);
    rst = 1'b0;
    chk_en = 1'b1;

    // Fill then drain
    cyc(0, 1, 16'h0002, 16'h8001, 0);
    cyc(0, 1, 16'h0004, 16'h8002, 0);
    chk("fill_count",    32'(bus.count), 2);
    chk("fill_in_ready", 32'(bus.in_ready), 0);
    chk("fill_head",     32'(bus.out_pc), 32'h0002);
    cyc(0, 0, 16'h0, 16'h0, 1);
    chk("drain_head2",   32'(bus.out_pc), 32'h0004);
    cyc(0, 0, 16'h0, 16'h0, 1);
    chk("drain_count",   32'(bus.count), 0);
    chk("drain_order0",  delivered[0], 32'h0002_8001);
    chk("drain_order1",  delivered[1], 32'h0004_8002);

    // Simultaneous enq+deq at count=1 and at full
    cyc(0, 1, 16'h0010, 16'h8010, 0);
    cyc(0, 1, 16'h0012, 16'h8012, 1);
    chk("sim1_count", 32'(bus.count), 1);
    chk("sim1_head",  32'(bus.out_pc), 32'h0012);
    cyc(0, 1, 16'h0014, 16'h8014, 0);
    cyc(0, 1, 16'h0016, 16'h8016, 1);
    chk("simfull_count", 32'(bus.count), 1);
    chk("simfull_head",  32'(bus.out_pc), 32'h0014);
    cyc(0, 0, 16'h0, 16'h0, 1);

    // HALT detect, blocking, and delivery
    cyc(0, 1, 16'h0006, 16'h0000, 0);
    chk("halt_set",      32'(bus.halt_seen), 1);
    chk("halt_in_ready", 32'(bus.in_ready), 0);
    cyc(0, 1, 16'h0008, 16'h8888, 0);
    chk("halt_block_count", 32'(bus.count), 1);
    chk("halt_head_instr",  32'(bus.out_instr), 32'h0000);
    cyc(0, 0, 16'h0, 16'h0, 1);
    chk("halt_delivered", delivered[delivered.size()-1], 32'h0006_0000);
    chk("halt_sticky",    32'(bus.halt_seen), 1);
    cyc(1, 0, 16'h0, 16'h0, 0);
    chk("halt_flushed",   32'(bus.halt_seen), 0);

    // Flush at full with halt set and a same-cycle enqueue
    cyc(0, 1, 16'h000A, 16'h8000, 0);
    cyc(0, 1, 16'h000C, 16'h0000, 0);
    chk("pre_flush_count", 32'(bus.count), 2);
    chk("pre_flush_halt",  32'(bus.halt_seen), 1);
    cyc(1, 1, 16'h000E, 16'h9999, 0);
    chk("flush_count",     32'(bus.count), 0);
    chk("flush_out_valid", 32'(bus.out_valid), 0);
    chk("flush_halt",      32'(bus.halt_seen), 0);
    chk("flush_in_ready",  32'(bus.in_ready), 1);
    cyc(0, 1, 16'h0020, 16'h8020, 0);
    chk("post_flush_count", 32'(bus.count), 1);
    chk("post_flush_head",  32'(bus.out_pc), 32'h0020);
    cyc(0, 0, 16'h0, 16'h0, 1);

    // Wrap: stream ten instructions with random out_ready
    base = delivered.size();
    sent = 0;
    budget = 0;
    while ((sent < 10 || mq.size() > 0) && budget < 200) begin
      if (sent < 10)
        cyc(0, 1, 16'(16'h1000 + sent), 16'(16'h8000 + sent), 1'($urandom_range(0, 1)));
      else
        cyc(0, 0, 16'h0, 16'h0, 1'($urandom_range(0, 1)));
      if (m_enq) sent++;
      budget++;
    end
    chk("wrap_done", 32'(budget < 200), 1);
    chk("wrap_len",  32'(delivered.size() - base), 10);
    for (int i = 0; i < 10 && base + i < delivered.size(); i++)
      chk("wrap_order", delivered[base+i], {16'(16'h1000 + i), 16'(16'h8000 + i)});

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      r_ins = 16'($urandom);
      if ($urandom_range(0, 7) == 0) r_ins[15:11] = 5'b00000;
      cyc(($urandom_range(0, 19) == 0), 1'($urandom_range(0, 1)), 16'($urandom),
          r_ins, 1'($urandom_range(0, 1)));
    end

    // Asynchronous reset mid-operation
    cyc(1, 0, 16'h0, 16'h0, 0);
    cyc(0, 1, 16'h0030, 16'h8030, 0);
    #2;
    rst = 1'b1;
    mq.delete();
    m_halt = 1'b0;
    #1;
    chk("arst_count",     32'(bus.count), 0);
    chk("arst_out_valid", 32'(bus.out_valid), 0);
    chk("arst_in_ready",  32'(bus.in_ready), 1);
    chk("arst_out_pc",    32'(bus.out_pc), 0);
    #2;
    rst = 1'b0;
    cyc(0, 1, 16'h0040, 16'h8040, 0);
    chk("arst_after_head", 32'(bus.out_pc), 32'h0040);
    cyc(0, 0, 16'h0, 16'h0, 1);

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
